prog_lut: RTL and testbench
===========================

Name: prog_lut

Overview:
- Writable, parametrised successor to the fixed 16-entry target/address lookup table in the 3BC processor.
- Holds DEPTH signed offsets, each DATA_W bits wide. Software or the loader writes entries at run time.
- Two independent read channels: channel 0 feeds PC target, channel 1 feeds data-memory address.
- Registered reads with valid flags, per-channel absolute/PC-relative mode, and a hardware clear sweep.

Parameters:
- IDX_W, 4, index width; DEPTH = 2**IDX_W entries.
- DATA_W, 10, entry and output width. Entries are two's-complement.

Ports:
- Clk  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- WrEn  in  1  write strobe.
- WrIdx  in  IDX_W  write index.
- WrData  in  DATA_W  write value.
- Clr  in  1  one-cycle pulse; starts clear sweep.
- Busy  out  1  high while clear sweep runs.
- RdReq0, RdReq1  in  1 each  read request, channel 0 / channel 1.
- RdIdx0, RdIdx1  in  IDX_W each  read index.
- Rel0, Rel1  in  1 each  1 = output PcIn + entry; 0 = output entry.
- PcIn  in  DATA_W  base value for relative mode, sampled with the request.
- Out0, Out1  out  DATA_W each  registered result.
- Valid0, Valid1  out  1 each  result valid, one-cycle pulse per accepted request.

Behaviour:
- Reset (Reset low, asynchronous):
  - All entries = 0; Out0 = Out1 = 0; Valid0 = Valid1 = 0; Busy = 0; FSM = IDLE.
  - Takes effect mid-sweep and mid-read; pending results are discarded.
- FSM states IDLE and CLEAR, with counter ClrPtr (IDX_W bits).
  - IDLE -> CLEAR on Clr = 1. ClrPtr := 0 and Busy := 1 on the following edge.
  - CLEAR: each cycle entry[ClrPtr] := 0 and ClrPtr++.
  - When ClrPtr == DEPTH-1, that entry is cleared and the FSM returns to IDLE.
  - Busy is high for exactly DEPTH cycles.
  - Clr while in CLEAR is ignored; the sweep does not restart.
- Writes:
  - In IDLE, WrEn = 1 writes entry[WrIdx] := WrData at the clock edge.
  - In CLEAR, WrEn is ignored; the write is dropped with no error.
- Reads, latency 1:
  - In IDLE, RdReqN = 1 at edge k gives ValidN = 1 and OutN valid after edge k+1's register update.
  - ValidN deasserts the next cycle unless a new request arrives. Back-to-back requests give continuous Valid.
  - OutN holds its last value when not valid.
- Read during CLEAR:
  - Request is not accepted; ValidN stays 0 and OutN holds.
  - The requester must watch Busy and retry.
- Read/write collision, same edge and same index:
  - The read returns WrData (write-through forwarding), not the old entry.
  - Applies independently to both channels.
- Both channels reading the same index: both return the same value. No arbitration needed.
- Relative mode, RelN = 1:
  - OutN = (PcIn + entry) mod 2^DATA_W; carry out is discarded (wrap-around).
  - Absolute mode: OutN = entry, bit-exact.
  - Both channels share the same sampled PcIn.
- Index range: every IDX_W-bit index is in range, so no out-of-range case exists.

Optional Feature:
- Macro: PROG_LUT_WR_LOCK_EN.
- Defined:
  - Adds input Lock (1 bit) and output WrErr (1 bit, reset 0).
  - A cycle with Lock = 1 sets a sticky lock flag, cleared only by Reset. Clr does not clear it.
  - While locked, writes are dropped and WrErr pulses high one cycle after each attempted write.
  - Clr sweeps are also refused while locked: Busy stays 0 and WrErr pulses.
  - Reads are unaffected.
- Undefined: Lock and WrErr ports do not exist; writes behave as above.

Test Plan:
- Reset, then read idx 5 on channel 0 with Rel0 = 0 -> Valid0 pulses one cycle later, Out0 = 0.
- Write idx 5 = -408 (10'h268), then read idx 5 absolute -> Out0 = 10'h268.
- Same entry, Rel1 = 1, PcIn = 500 -> Out1 = 92; PcIn = 10'h3FF with entry = 2 -> Out1 = 1 (wrap).
- Same-cycle write idx 3 = 77 and read idx 3 on both channels -> Out0 = Out1 = 77.
- Fill all 16 entries, pulse Clr:
  - Busy is high for 16 cycles.
  - A write during the sweep is dropped.
  - A read during the sweep gives no Valid.
  - After the sweep, reads of all 16 indices return 0.
- With PROG_LUT_WR_LOCK_EN:
  - Write idx 2 = 9, pulse Lock, then write idx 2 = 4 -> WrErr pulses and a read of idx 2 returns 9.
  - Clr while locked -> Busy stays 0.
  - Assert Reset mid-sweep -> Busy = 0, lock flag cleared, entries = 0.

Source files
------------

// File: rtl/prog_lut.sv
// Writable signed-offset lookup table with two registered read channels and a clear sweep.
// Optional write lock enabled by defining PROG_LUT_WR_LOCK_EN.
module prog_lut #(
  parameter int unsigned IDX_W  = 4,
  parameter int unsigned DATA_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              clr,
  output logic              busy,
  input  logic              rd_req0,
  input  logic              rd_req1,
  input  logic [IDX_W-1:0]  rd_idx0,
  input  logic [IDX_W-1:0]  rd_idx1,
  input  logic              rel0,
  input  logic              rel1,
  input  logic [DATA_W-1:0] pc_in,
`ifdef PROG_LUT_WR_LOCK_EN
  input  logic              lock,
  output logic              wr_err,
`endif
  output logic [DATA_W-1:0] out0,
  output logic [DATA_W-1:0] out1,
  output logic              valid0,
  output logic              valid1
);

  localparam int unsigned DEPTH = 2 ** IDX_W;

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  out0_q, out1_q;
  logic               valid0_q, valid1_q;

  logic               idle, locked, wr_fire, clr_start;
  logic               acc0, acc1;
  logic [DATA_W-1:0]  rd_data0, rd_data1, res0, res1;

`ifdef PROG_LUT_WR_LOCK_EN
  logic lock_q, wr_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      lock_q   <= lock_q | lock;
      // Dropped writes and refused sweeps both report one cycle later.
      wr_err_q <= lock_q & (wr_en | (clr & idle));
    end
  end

  assign locked = lock_q;
  assign wr_err = wr_err_q;
`else
  assign locked = 1'b0;
`endif

  always_comb begin
    idle      = (state_q == StIdle);
    wr_fire   = idle & wr_en & ~locked;
    clr_start = idle & clr & ~locked;
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      StIdle: begin
        if (clr_start) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (&clr_ptr_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    acc0     = rd_req0 & idle;
    acc1     = rd_req1 & idle;
    // Same-edge write to the read index is forwarded to the reader.
    rd_data0 = (wr_fire && (wr_idx == rd_idx0)) ? wr_data : mem_q[rd_idx0];
    rd_data1 = (wr_fire && (wr_idx == rd_idx1)) ? wr_data : mem_q[rd_idx1];
    res0     = rel0 ? (pc_in + rd_data0) : rd_data0;
    res1     = rel1 ? (pc_in + rd_data1) : rd_data1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (state_q == StClear) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (wr_fire) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_q   <= '0;
      out1_q   <= '0;
      valid0_q <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      valid0_q <= acc0;
      valid1_q <= acc1;
      if (acc0) out0_q <= res0;
      if (acc1) out1_q <= res1;
    end
  end

  assign busy   = (state_q == StClear);
  assign out0   = out0_q;
  assign out1   = out1_q;
  assign valid0 = valid0_q;
  assign valid1 = valid1_q;

endmodule

// File: tb/tb_prog_lut.sv
// Directed self-checking bench for prog_lut; covers the lock feature when
// PROG_LUT_WR_LOCK_EN is defined.
module tb_prog_lut;

  localparam int unsigned IDX_W  = 4;
  localparam int unsigned DATA_W = 10;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [DATA_W-1:0] wr_data;
  logic              clr;
  logic              busy;
  logic              rd_req0, rd_req1;
  logic [IDX_W-1:0]  rd_idx0, rd_idx1;
  logic              rel0, rel1;
  logic [DATA_W-1:0] pc_in;
  logic [DATA_W-1:0] out0, out1;
  logic              valid0, valid1;
`ifdef PROG_LUT_WR_LOCK_EN
  logic              lock;
  logic              wr_err;
`endif

  int n_vec = 0;
  int n_bad = 0;
  int busy_cnt;

  prog_lut #(
    .IDX_W  (IDX_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .clr     (clr),
    .busy    (busy),
    .rd_req0 (rd_req0),
    .rd_req1 (rd_req1),
    .rd_idx0 (rd_idx0),
    .rd_idx1 (rd_idx1),
    .rel0    (rel0),
    .rel1    (rel1),
    .pc_in   (pc_in),
`ifdef PROG_LUT_WR_LOCK_EN
    .lock    (lock),
    .wr_err  (wr_err),
`endif
    .out0    (out0),
    .out1    (out1),
    .valid0  (valid0),
    .valid1  (valid1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_idx = '0; wr_data = '0; clr = 0;
    rd_req0 = 0; rd_req1 = 0; rd_idx0 = '0; rd_idx1 = '0;
    rel0 = 0; rel1 = 0; pc_in = '0;
`ifdef PROG_LUT_WR_LOCK_EN
    lock = 0;
`endif
  endtask

  task automatic write(input logic [IDX_W-1:0] idx, input logic [DATA_W-1:0] val);
    wr_en = 1; wr_idx = idx; wr_data = val;
    tick();
    wr_en = 0;
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    #23;
    rst_n = 1;
    tick();

    check_eq("rst_out0", 32'(out0), 32'h0);
    check_eq("rst_out1", 32'(out1), 32'h0);
    check_eq("rst_valid", 32'({valid0, valid1}), 32'h0);
    check_eq("rst_busy", 32'(busy), 32'h0);

    // Read of a reset entry.
    rd_req0 = 1; rd_idx0 = 4'd5;
    tick();
    rd_req0 = 0;
    check_eq("rd5_valid", 32'(valid0), 32'h1);
    check_eq("rd5_zero", 32'(out0), 32'h0);
    tick();
    check_eq("rd5_valid_drop", 32'(valid0), 32'h0);

    write(4'd5, 10'h268);
    rd_req0 = 1; rd_idx0 = 4'd5;
    tick();
    rd_req0 = 0;
    check_eq("abs_m408", 32'(out0), 32'h268);

    // Relative: -408 + 500 = 92; channel 0 absolute at the same time.
    rd_req0 = 1; rd_idx0 = 4'd5; rd_req1 = 1; rd_idx1 = 4'd5; rel1 = 1; pc_in = 10'd500;
    tick();
    rd_req0 = 0; rd_req1 = 0; rel1 = 0;
    check_eq("rel_92", 32'(out1), 32'd92);
    check_eq("abs_same_cycle", 32'(out0), 32'h268);
    check_eq("rel_valid1", 32'(valid1), 32'h1);

    write(4'd5, 10'd2);
    rd_req1 = 1; rd_idx1 = 4'd5; rel1 = 1; pc_in = 10'h3FF;
    tick();
    rd_req1 = 0; rel1 = 0;
    check_eq("rel_wrap", 32'(out1), 32'd1);

    // Write-through forwarding on both channels.
    wr_en = 1; wr_idx = 4'd3; wr_data = 10'd77;
    rd_req0 = 1; rd_idx0 = 4'd3; rd_req1 = 1; rd_idx1 = 4'd3;
    tick();
    wr_en = 0; rd_req0 = 0; rd_req1 = 0;
    check_eq("fwd_out0", 32'(out0), 32'd77);
    check_eq("fwd_out1", 32'(out1), 32'd77);
    tick();
    check_eq("hold_valid", 32'({valid0, valid1}), 32'h0);
    check_eq("hold_out0", 32'(out0), 32'd77);

    for (int i = 0; i < 16; i++) write(4'(i), 10'(i + 100));
    rd_req0 = 1; rd_idx0 = 4'd15; rd_req1 = 1; rd_idx1 = 4'd0;
    tick();
    rd_req0 = 0; rd_req1 = 0;
    check_eq("fill_15", 32'(out0), 32'd115);
    check_eq("fill_0", 32'(out1), 32'd100);

    // Clear sweep with a re-pulse of clr, a dropped write and a refused read.
    clr = 1;
    tick();
    clr = 0;
    busy_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) break;
      busy_cnt++;
      if (k == 0) begin rd_req0 = 1; rd_idx0 = 4'd15; end
      if (k == 5) clr = 1;
      if (k == 15) begin wr_en = 1; wr_idx = 4'd0; wr_data = 10'd99; end
      tick();
      if (k == 0) begin
        check_eq("sweep_rd_valid", 32'(valid0), 32'h0);
        check_eq("sweep_rd_hold", 32'(out0), 32'd115);
      end
      rd_req0 = 0; clr = 0; wr_en = 0;
    end
    check_eq("busy_cycles", busy_cnt, 32'd16);

    for (int i = 0; i < 16; i++) begin
      rd_req0 = 1; rd_idx0 = 4'(i); rd_req1 = 1; rd_idx1 = 4'(15 - i);
      tick();
      check_eq("swept0", 32'({valid0, out0}), {21'h0, 1'b1, 10'h0});
      check_eq("swept1", 32'({valid1, out1}), {21'h0, 1'b1, 10'h0});
    end
    rd_req0 = 0; rd_req1 = 0;

`ifdef PROG_LUT_WR_LOCK_EN
    write(4'd2, 10'd9);
    lock = 1;
    tick();
    lock = 0;
    check_eq("lock_no_err", 32'(wr_err), 32'h0);
    write(4'd2, 10'd4);
    check_eq("lock_wr_err", 32'(wr_err), 32'h1);
    rd_req0 = 1; rd_idx0 = 4'd2;
    tick();
    rd_req0 = 0;
    check_eq("lock_err_pulse", 32'(wr_err), 32'h0);
    check_eq("lock_keeps_9", 32'(out0), 32'd9);
    clr = 1;
    tick();
    clr = 0;
    check_eq("lock_clr_err", 32'(wr_err), 32'h1);
    check_eq("lock_clr_busy", 32'(busy), 32'h0);

    // Reset mid-sweep; lock is released too.
    rst_n = 0;
    #3;
    rst_n = 1;
    write(4'd4, 10'd5);
    clr = 1;
    tick();
    clr = 0;
    tick();
    tick();
    check_eq("sweep_running", 32'(busy), 32'h1);
    rst_n = 0;
    #1;
    check_eq("rst_mid_busy", 32'(busy), 32'h0);
    #3;
    rst_n = 1;
    rd_req0 = 1; rd_idx0 = 4'd2;
    tick();
    rd_req0 = 0;
    check_eq("rst_entry_zero", 32'(out0), 32'h0);
    write(4'd4, 10'd6);
    check_eq("unlocked_err", 32'(wr_err), 32'h0);
    rd_req0 = 1; rd_idx0 = 4'd4;
    tick();
    rd_req0 = 0;
    check_eq("unlocked_wr", 32'(out0), 32'd6);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
